// File: rtl/dispenser.sv
// dispenser: drains a loaded total as step-sized chunks over valid/ready.
// Optional macro DISPENSER_REMAINDER_EN also emits the final short chunk.
module dispenser (
  input  logic        clock,
  input  logic        clear,
  input  logic        load,
  input  logic        step_load,
  input  logic        start,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] balance,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] step;
  logic [15:0] step_nx;
  logic [15:0] balance_nx;
  logic [15:0] chunk;
  logic [15:0] rest;
  logic        emit_now;
  logic        emit_rest;

  // chunk size and what remains once it is accepted
  always_comb begin
    chunk = (balance >= step) ? step : balance;
    rest  = balance - chunk;
  end

  // whether there is something to emit now, and after an accept
  always_comb begin
`ifdef DISPENSER_REMAINDER_EN
    emit_now  = (step != 16'd0) && (balance != 16'd0);
    emit_rest = (step != 16'd0) && (rest != 16'd0);
`else
    emit_now  = (step != 16'd0) && (balance >= step);
    emit_rest = (step != 16'd0) && (rest >= step);
`endif
  end

  // state, balance and step registers with synchronous clear
  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= IDLE;
      balance <= 16'd0;
      step    <= 16'd0;
    end else begin
      state   <= state_nx;
      balance <= balance_nx;
      step    <= step_nx;
    end
  end

  // next-state, register updates and handshake outputs
  always_comb begin
    state_nx   = state;
    balance_nx = balance;
    step_nx    = step;
    data_out   = 16'd0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          balance_nx = data_in;
        end else if (step_load) begin
          step_nx = data_in;
        end else if (start) begin
          state_nx = emit_now ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        data_out  = chunk;
        if (out_ready) begin
          balance_nx = rest;
          state_nx   = emit_rest ? DRAIN : DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dispenser.sv
// tb_dispenser: scoreboard bench for the dispenser.
// Expected chunks are queued at start and popped on each accept.
module tb_dispenser;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic        step_load = 1'b0;
  logic        start = 1'b0;
  logic [15:0] data_in = 16'd0;
  logic [15:0] data_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] balance;
  logic        busy;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb[$];
  logic [15:0] resid;

  dispenser dut (
    .clock     (clock),
    .clear     (clear),
    .load      (load),
    .step_load (step_load),
    .start     (start),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .balance   (balance),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // reference model: queue expected chunks and the residual
  task automatic push_model(input logic [15:0] bal,
                            input logic [15:0] st);
    logic [15:0] b;
    logic [15:0] c;
    logic        go;
    b = bal;
    sb.delete();
    go = 1'b1;
    while (go) begin
`ifdef DISPENSER_REMAINDER_EN
      go = (st != 0) && (b != 0);
`else
      go = (st != 0) && (b >= st);
`endif
      if (go) begin
        c = (b >= st) ? st : b;
        sb.push_back(c);
        b = b - c;
      end
    end
    resid = b;
  endtask

  task automatic start_run(input logic [15:0] bal,
                           input logic [15:0] st);
    load = 1'b1;
    data_in = bal;
    cycle();
    load = 1'b0;
    step_load = 1'b1;
    data_in = st;
    cycle();
    step_load = 1'b0;
    push_model(bal, st);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // consume chunks until done, scoring each accepted one
  task automatic collect(input string name, input int budget);
    int          n;
    logic [15:0] exp;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s bubble out_valid=%b need 1",
                 name, out_valid);
      end else if (out_ready) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s extra chunk got %0d need none",
                   name, data_out);
        end else begin
          exp = sb.pop_front();
          if (data_out !== exp) begin
            errors++;
            $display("FAIL %s chunk got %0d need %0d",
                     name, data_out, exp);
          end
        end
      end
      cycle();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout done=%b need 1", name, done);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s missing chunks got %0d left need 0",
               name, sb.size());
    end
    sb.delete();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_in_done got %b need 0",
               name, out_valid);
    end
    checks++;
    if (balance !== resid) begin
      errors++;
      $display("FAIL %s residual got %0d need %0d",
               name, balance, resid);
    end
    cycle();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle got done=%b busy=%b need 0 0",
               name, done, busy);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset ctl got %b%b%b need 000",
               out_valid, busy, done);
    end
    checks++;
    if (balance !== 16'd0 || data_out !== 16'd0) begin
      errors++;
      $display("FAIL reset data got bal=%0d out=%0d need 0 0",
               balance, data_out);
    end
  endtask

  task automatic test_full_drain();
    out_ready = 1'b1;
    start_run(16'd10, 16'd3);
    collect("full_drain", 20);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    start_run(16'd8, 16'd4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || data_out !== 16'd4 ||
          balance !== 16'd8) begin
        errors++;
        $display("FAIL stall got v=%b out=%0d bal=%0d need 1 4 8",
                 out_valid, data_out, balance);
      end
      cycle();
    end
    out_ready = 1'b1;
    collect("backpressure", 20);
  endtask

  task automatic test_degenerate();
    out_ready = 1'b1;
    start_run(16'd5, 16'd0);
    collect("step_zero", 1);
    start_run(16'd0, 16'd2);
    collect("bal_zero", 1);
  endtask

  task automatic test_priority();
    out_ready = 1'b1;
    step_load = 1'b1;
    data_in = 16'd2;
    cycle();
    load = 1'b1;
    data_in = 16'd7;
    cycle();
    step_load = 1'b0;
    checks++;
    if (balance !== 16'd7) begin
      errors++;
      $display("FAIL prio_bal got %0d need 7", balance);
    end
    start = 1'b1;
    cycle();
    load = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_with_load got busy=%b done=%b need 0 0",
               busy, done);
    end
    push_model(16'd7, 16'd2);
    start = 1'b1;
    cycle();
    start = 1'b0;
    collect("priority", 20);
  endtask

  task automatic test_lockout();
    out_ready = 1'b0;
    start_run(16'd10, 16'd3);
    load = 1'b1;
    step_load = 1'b1;
    data_in = 16'd100;
    cycle();
    cycle();
    load = 1'b0;
    step_load = 1'b0;
    checks++;
    if (balance !== 16'd10 || data_out !== 16'd3) begin
      errors++;
      $display("FAIL lockout got bal=%0d out=%0d need 10 3",
               balance, data_out);
    end
    out_ready = 1'b1;
    collect("lockout", 20);
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    start_run(16'd9, 16'd2);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 16'd2) begin
      errors++;
      $display("FAIL clr_first got v=%b out=%0d need 1 2",
               out_valid, data_out);
    end
    cycle();
    checks++;
    if (balance !== 16'd7) begin
      errors++;
      $display("FAIL clr_bal got %0d need 7", balance);
    end
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        balance !== 16'd0 || data_out !== 16'd0) begin
      errors++;
      $display("FAIL clr_state got v=%b b=%b d=%b bal=%0d need 0 0 0 0",
               out_valid, busy, done, balance);
    end
    cycle();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL clr_no_done got %b need 0", done);
    end
    // step was cleared to zero, so a start finishes at once
    load = 1'b1;
    data_in = 16'd5;
    cycle();
    load = 1'b0;
    push_model(16'd5, 16'd0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    collect("clr_step_zero", 1);
  endtask

  initial begin
    test_reset();
    test_full_drain();
    test_backpressure();
    test_degenerate();
    test_priority();
    test_lockout();
    test_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
